// File: rtl/mem_stage_pkg.sv
// Shared CPU types for the NES core: operation encodings, register ids and
// small decode helpers used by the pipeline stages.
package mem_stage_pkg;

  localparam int BYTE = 8;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_EOR,
    ALU_ASL, ALU_LSR, ALU_ROL, ALU_ROR, ALU_PASS
  } alu_op_t;

  typedef enum logic [2:0] {
    MEM_NONE, MEM_LD8, MEM_ST8, MEM_LD16, MEM_LD16_PW, MEM_ST16
  } mem_op_t;

  typedef enum logic [1:0] {
    REG_A, REG_X, REG_Y, REG_NONE
  } reg_id_t;

  function automatic logic is_store(mem_op_t op);
    return (op == MEM_ST8) || (op == MEM_ST16);
  endfunction

  // Two-byte accesses walk through ACC_LO then ACC_HI.
  function automatic logic is_wide(mem_op_t op);
    return (op == MEM_LD16) || (op == MEM_LD16_PW) || (op == MEM_ST16);
  endfunction

endpackage

// File: rtl/mem_stage.sv
// Memory stage: performs the 8/16-bit CPU bus access an instruction needs via
// a req/ack handshake and hands the result to writeback with valid/ready.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [15:0]       alu_res_i,
  input  mem_op_t           mem_op_i,
  input  logic [15:0]       st_data_i,
  input  logic [1:0]        rd_i,
  input  logic [7:0]        status_reg_i,
  input  logic              flush_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [15:0]       res_o,
  output logic [1:0]        rd_o,
  output logic [7:0]        status_reg_o
);

  typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, DONE} state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         st_q;
  mem_op_t             op_q;
  logic                kill_q;
  logic                accept;
  logic                ack;
  logic                kill_now;
  logic [ADDR_W-1:0]   hi_addr;

  assign ready_o  = (state == IDLE) | ((state == DONE) & ready_i);
  assign accept   = valid_i & ready_o & ~flush_i;
  // Acks only count while a request is actually outstanding.
  assign ack      = bus_ack_i & bus_req_o;
  assign kill_now = kill_q | flush_i;

  // The page-wrap variant reproduces the 6502 JMP (ind) bug: no carry into the high byte.
  assign hi_addr = (op_q == MEM_LD16_PW) ? {addr_q[15:8], addr_q[7:0] + 8'd1}
                                         : addr_q + 16'd1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_d;
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (accept) state_d = (mem_op_i == MEM_NONE) ? DONE : ACC_LO;
      end
      ACC_LO: begin
        if (ack) begin
          if (kill_now)           state_d = IDLE;
          else if (is_wide(op_q)) state_d = ACC_HI;
          else                    state_d = DONE;
        end
      end
      ACC_HI: begin
        if (ack) state_d = kill_now ? IDLE : DONE;
      end
      DONE: begin
        if (flush_i)      state_d = IDLE;
        else if (accept)  state_d = (mem_op_i == MEM_NONE) ? DONE : ACC_LO;
        else if (ready_i) state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q       <= '0;
      st_q         <= '0;
      op_q         <= MEM_NONE;
      kill_q       <= 1'b0;
      bus_req_o    <= 1'b0;
      bus_we_o     <= 1'b0;
      bus_addr_o   <= '0;
      bus_wdata_o  <= '0;
      valid_o      <= 1'b0;
      res_o        <= '0;
      rd_o         <= '0;
      status_reg_o <= '0;
    end else if (accept) begin
      addr_q       <= alu_res_i;
      st_q         <= st_data_i;
      op_q         <= mem_op_i;
      kill_q       <= 1'b0;
      rd_o         <= rd_i;
      status_reg_o <= status_reg_i;
      if (mem_op_i == MEM_NONE) begin
        res_o   <= alu_res_i;
        valid_o <= 1'b1;
      end else begin
        valid_o     <= 1'b0;
        bus_req_o   <= 1'b1;
        bus_addr_o  <= alu_res_i;
        bus_we_o    <= is_store(mem_op_i);
        bus_wdata_o <= st_data_i[BYTE-1:0];
      end
    end else begin
      case (state)
        DONE: begin
          if (flush_i || ready_i) valid_o <= 1'b0;
        end
        ACC_LO, ACC_HI: begin
          if (flush_i) kill_q <= 1'b1;
          if (ack) begin
            if (kill_now) begin
              // A killed access still finishes its handshake, then the stage goes quiet.
              bus_req_o <= 1'b0;
              bus_we_o  <= 1'b0;
              kill_q    <= 1'b0;
            end else if ((state == ACC_LO) && is_wide(op_q)) begin
              bus_addr_o  <= hi_addr;
              bus_wdata_o <= st_q[15:8];
              if (!is_store(op_q)) res_o[7:0] <= bus_rdata_i;
            end else begin
              bus_req_o <= 1'b0;
              bus_we_o  <= 1'b0;
              valid_o   <= 1'b1;
              if (is_store(op_q))      res_o       <= addr_q;
              else if (state == ACC_LO) res_o      <= {8'h00, bus_rdata_i};
              else                     res_o[15:8] <= bus_rdata_i;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
